// File: rtl/sum_arbiter.sv
// sum_arbiter: round-robin sharing of one saturating signed adder among NREQ
// requesters. Stage 1 arbitrates and captures the winner's operands; stage 2
// adds with clipping and presents the tagged result. A counter tracks how
// many results were clipped.
module sum_arbiter #(
   parameter int Width = 16,
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int CNTW  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*Width-1:0]   a_bus,
   input  logic [NREQ*Width-1:0]   b_bus,
   output logic [NREQ-1:0]         gnt,
   output logic signed [Width-1:0] y,
   output logic                    y_valid,
   output logic [IDW-1:0]          y_id,
   output logic                    y_sat,
   output logic [CNTW-1:0]         sat_cnt,
   input  logic                    sat_clr
);

   // Saturating signed add; returns {clipped, result}.
   function automatic logic [Width:0] sat_add(input logic signed [Width-1:0] a,
                                              input logic signed [Width-1:0] b);
      logic signed [Width-1:0] s;
      logic                    ovf;
      logic                    unf;
      s   = a + b;
      ovf = !a[Width-1] && !b[Width-1] &&  s[Width-1];
      unf =  a[Width-1] &&  b[Width-1] && !s[Width-1];
      if (ovf) return {1'b1, 1'b0, {(Width-1){1'b1}}};
      if (unf) return {1'b1, 1'b1, {(Width-1){1'b0}}};
      return {1'b0, s};
   endfunction

   // Requester index base+off, wrapped modulo NREQ (off < NREQ).
   function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] base,
                                               input int             off);
      int t;
      t = int'(base) + off;
      if (t >= NREQ) t = t - NREQ;
      return IDW'(t);
   endfunction

   logic [IDW-1:0]          ptr;
   logic [NREQ-1:0]         elig;
   logic                    found;
   logic [IDW-1:0]          sel;
   logic [IDW-1:0]          cand;

   logic signed [Width-1:0] a_p1;
   logic signed [Width-1:0] b_p1;
   logic [IDW-1:0]          id_p1;
   logic                    vld_p1;
   logic [Width:0]          add_p1;

   // Round-robin search: first eligible requester at or after ptr. A requester
   // whose grant is currently showing is skipped so it cannot be issued twice.
   always_comb begin
      elig  = req & ~gnt;
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = next_idx(ptr, off);
         if (!found && elig[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // ---- stage 1: arbitration control (grant pulse, pointer, valid) ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt    <= '0;
         ptr    <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= found;
         gnt    <= found ? (NREQ'(1'b1) << sel) : '0;
         if (found) ptr <= next_idx(sel, 1);
      end
   end

   // Stage 1 operand/tag capture for the winning requester.
   always_ff @(posedge clk) begin
      if (found) begin
         a_p1  <= a_bus[int'(sel)*Width +: Width];
         b_p1  <= b_bus[int'(sel)*Width +: Width];
         id_p1 <= sel;
      end
   end

   assign add_p1 = sat_add(a_p1, b_p1);

   // ---- stage 2: clipped sum, tag and valid; y/y_id hold when idle ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y       <= '0;
         y_id    <= '0;
         y_valid <= 1'b0;
         y_sat   <= 1'b0;
      end else begin
         y_valid <= vld_p1;
         y_sat   <= vld_p1 & add_p1[Width];
         if (vld_p1) begin
            y    <= add_p1[Width-1:0];
            y_id <= id_p1;
         end
      end
   end

   // Clip-event counter: clear wins over increment, sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || sat_clr) begin
         sat_cnt <= '0;
      end else if (y_valid && y_sat && (sat_cnt != '1)) begin
         sat_cnt <= sat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed testbench for sum_arbiter (Width=16, NREQ=4, IDW=2, CNTW=8).
module tb_sum_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   logic                clk;
   logic                rst_n;
   logic [N-1:0]        req;
   logic [N*W-1:0]      a_bus;
   logic [N*W-1:0]      b_bus;
   logic [N-1:0]        gnt;
   logic signed [W-1:0] y;
   logic                y_valid;
   logic [1:0]          y_id;
   logic                y_sat;
   logic [7:0]          sat_cnt;
   logic                sat_clr;

   int checks   = 0;
   int failures = 0;

   sum_arbiter #(.Width(W), .NREQ(N), .IDW(2), .CNTW(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
      .gnt(gnt), .y(y), .y_valid(y_valid), .y_id(y_id), .y_sat(y_sat),
      .sat_cnt(sat_cnt), .sat_clr(sat_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled and inputs changed 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_bus[i*W +: W] = a;
      b_bus[i*W +: W] = b;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; sat_clr = 1'b0; a_bus = '0; b_bus = '0;
      tick(); tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (y !== 16'sd0) begin failures++; $display("FAIL reset_y got=%0h exp=0", y); end
      checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
      checks++; if (y_id !== 2'd0) begin failures++; $display("FAIL reset_y_id got=%0d exp=0", y_id); end
      checks++; if (y_sat !== 1'b0) begin failures++; $display("FAIL reset_y_sat got=%b exp=0", y_sat); end
      checks++; if (sat_cnt !== 8'd0) begin failures++; $display("FAIL reset_sat_cnt got=%0d exp=0", sat_cnt); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (y_valid !== 1'b0 || gnt !== 4'b0000)
            begin failures++; $display("FAIL idle_outputs cyc=%0d got y_valid=%b gnt=%b exp 0/0000", i, y_valid, gnt); end
      end
   endtask

   task automatic test_single();
      set_lane(2, 16'd100, -16'sd30);
      req = 4'b0100;
      tick();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
      checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL single_lat got=%b exp=0", y_valid); end
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_no_double got=%b exp=0000", gnt); end
      checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", y_valid); end
      checks++; if (y !== 16'sd70) begin failures++; $display("FAIL single_y got=%0d exp=70", y); end
      checks++; if (y_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", y_id); end
      checks++; if (y_sat !== 1'b0) begin failures++; $display("FAIL single_sat got=%b exp=0", y_sat); end
      tick();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_regrant got=%b exp=0100", gnt); end
      checks++; if (y_valid !== 1'b0 || y !== 16'sd70 || y_id !== 2'd2)
         begin failures++; $display("FAIL single_hold got=%b/%0d/%0d exp=0/70/2", y_valid, y, y_id); end
      req = 4'b0000;
      tick();
      checks++; if (gnt !== 4'b0000 || y_valid !== 1'b1)
         begin failures++; $display("FAIL single_second got gnt=%b v=%b exp 0000/1", gnt, y_valid); end
      tick();
      checks++; if (gnt !== 4'b0000 || y_valid !== 1'b0)
         begin failures++; $display("FAIL single_drain got gnt=%b v=%b exp 0000/0", gnt, y_valid); end
   endtask

   task automatic test_saturation();
      set_lane(0, 16'h7000, 16'h2000);
      set_lane(1, 16'h8001, 16'hFFF0);
      req = 4'b0011;
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL sat_gnt0 got=%b exp=0001", gnt); end
      req = 4'b0010;
      tick();
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL sat_gnt1 got=%b exp=0010", gnt); end
      checks++; if (y_valid !== 1'b1 || y !== 16'sh7FFF || y_sat !== 1'b1 || y_id !== 2'd0)
         begin failures++; $display("FAIL sat_ovf got v=%b y=%h s=%b id=%0d exp 1/7fff/1/0", y_valid, y, y_sat, y_id); end
      req = 4'b0000;
      tick();
      checks++; if (y_valid !== 1'b1 || y !== 16'sh8000 || y_sat !== 1'b1 || y_id !== 2'd1)
         begin failures++; $display("FAIL sat_unf got v=%b y=%h s=%b id=%0d exp 1/8000/1/1", y_valid, y, y_sat, y_id); end
      tick();
      checks++; if (y_sat !== 1'b0) begin failures++; $display("FAIL sat_idle got=%b exp=0", y_sat); end
      checks++; if (sat_cnt !== 8'd2) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=2", sat_cnt); end
      req = 4'b0001;
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL sat_gnt3 got=%b exp=0001", gnt); end
      req = 4'b0000;
      tick();
      checks++; if (y_valid !== 1'b1 || y_sat !== 1'b1)
         begin failures++; $display("FAIL sat_third got v=%b s=%b exp 1/1", y_valid, y_sat); end
      sat_clr = 1'b1;
      tick();
      checks++; if (sat_cnt !== 8'd0) begin failures++; $display("FAIL sat_clr_prio got=%0d exp=0", sat_cnt); end
      sat_clr = 1'b0;
      tick();
      checks++; if (sat_cnt !== 8'd0) begin failures++; $display("FAIL sat_clr_hold got=%0d exp=0", sat_cnt); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] prev;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_lane(i, W'(i*10+1), W'(i));
      req  = 4'b1111;
      prev = '0;
      for (int n = 0; n < 8; n++) begin
         tick();
         checks++; if (gnt !== (4'b0001 << (n % 4)))
            begin failures++; $display("FAIL rr_gnt n=%0d got=%b exp=%b", n, gnt, 4'b0001 << (n % 4)); end
         if (n >= 1) begin
            checks++; if ((gnt & prev) !== 4'b0000)
               begin failures++; $display("FAIL rr_consecutive n=%0d got=%b prev=%b exp disjoint", n, gnt, prev); end
            checks++; if (y_valid !== 1'b1 || y_id !== 2'((n-1) % 4) || y !== W'(11*((n-1) % 4)+1))
               begin failures++; $display("FAIL rr_result n=%0d got v=%b id=%0d y=%0d exp 1/%0d/%0d",
                                          n, y_valid, y_id, y, (n-1) % 4, 11*((n-1) % 4)+1); end
         end
         prev = gnt;
      end
      req = 4'b0000;
      tick(); tick();
   endtask

   task automatic test_counter_ceiling();
      int model;
      int results;
      model = 0; results = 0;
      set_lane(0, 16'h7000, 16'h2000);
      set_lane(1, 16'h8001, 16'hFFF0);
      req = 4'b0011;
      for (int n = 0; n < 275; n++) begin
         if (n == 270) req = 4'b0000;
         tick();
         checks++; if (sat_cnt !== 8'(model))
            begin failures++; $display("FAIL ceil_track n=%0d got=%0d exp=%0d", n, sat_cnt, model); end
         if (y_valid && y_sat) begin
            results++;
            if (model != 255) model++;
         end
      end
      checks++; if (results < 260) begin failures++; $display("FAIL ceil_results got=%0d exp>=260", results); end
      checks++; if (sat_cnt !== 8'd255) begin failures++; $display("FAIL ceil_final got=%0d exp=255", sat_cnt); end
   endtask

   task automatic test_reset_mid_op();
      set_lane(2, 16'd5, 16'd6);
      req = 4'b0100;
      tick();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rmid_gnt got=%b exp=0100", gnt); end
      rst_n = 1'b0; req = 4'b0000;
      tick();
      checks++; if (y_valid !== 1'b0 || gnt !== 4'b0000 || sat_cnt !== 8'd0)
         begin failures++; $display("FAIL rmid_flush got v=%b gnt=%b cnt=%0d exp 0/0000/0", y_valid, gnt, sat_cnt); end
      rst_n = 1'b1;
      tick();
      checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_result got=%b exp=0", y_valid); end
      for (int i = 0; i < N; i++) set_lane(i, W'(i), W'(1));
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_ptr got=%b exp=0001", gnt); end
      req = 4'b0000;
      tick();
      checks++; if (y_valid !== 1'b1 || y_id !== 2'd0 || y !== 16'sd1)
         begin failures++; $display("FAIL rmid_result got v=%b id=%0d y=%0d exp 1/0/1", y_valid, y_id, y); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_saturation();
      test_round_robin();
      test_counter_ceiling();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sum_arbiter.md
Name: sum_arbiter

Overview:
- Shares one saturating signed adder among NREQ requesters using round-robin arbitration and a 2-stage pipeline.
- Each requester presents an operand pair with a request; the block grants one requester per cycle and returns the saturated sum tagged with the requester ID.
- Sits between the servo control-loop stages (error, integral and output accumulation) and the single adder resource.

Parameters:
- Width, 16, operand/result bit width (two's complement).
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID (IDW >= clog2(NREQ)).
- CNTW, 8, width of the saturation-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NREQ  per-requester request; held high with operands stable until the matching gnt bit is seen.
- a_bus  in  NREQ*Width  operand A, requester i at bits [i*Width +: Width].
- b_bus  in  NREQ*Width  operand B, same packing.
- gnt  out  NREQ  registered one-hot grant pulse, 1 cycle.
- y  out  Width  registered saturated sum.
- y_valid  out  1  y/y_id/y_sat valid, 1-cycle pulse per operation.
- y_id  out  IDW  index of the requester that owns y.
- y_sat  out  1  this result was clipped (overflow or underflow).
- sat_cnt  out  CNTW  count of clipped results, saturates at all-ones.
- sat_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- All state is updated on the rising clk edge. Reset is synchronous: while rst_n=0 at an edge, gnt=0, y=0, y_valid=0, y_id=0, y_sat=0, sat_cnt=0, and the round-robin pointer resets to 0 (requester 0 has highest priority). In-flight operations are discarded; no y_valid is produced for them after reset.
- Eligibility: req[i]=1 and gnt[i]=0 in the current cycle. The grant pulse is visible to the requester only after capture, so this rule blocks double-issue. A single requester is served at most every other cycle.
- Arbitration, stage 1 (edge k):
  - Pick the first eligible index, searching from ptr upward and wrapping modulo NREQ.
  - Latch A_i, B_i and the index into stage-1 registers, set gnt[i]=1 for cycle k..k+1, and set ptr=(i+1) mod NREQ.
  - If no index is eligible: gnt=0, stage-1 valid=0, ptr unchanged.
- Compute, stage 2 (edge k+1):
  - sum = A+B, Width bits, wrap.
  - Overflow: A and B both positive (msb 0) and sum msb 1 → y = 0111…1.
  - Underflow: A and B both negative and sum msb 0 → y = 1000…0.
  - Otherwise y = sum.
  - y_sat = overflow|underflow. y_id and y_valid copy the stage-1 tag and valid.
- Latency: request sampled at edge k → result valid after edge k+1. Throughput is 1 result per cycle when at least 2 requesters are active.
- Idle outputs: y and y_id hold their last value when y_valid=0. y_sat is 0 whenever y_valid=0.
- sat_cnt increments by 1 when y_valid&y_sat, and holds at 2^CNTW−1.
  - sat_clr has priority over increment: a simultaneous clear and event gives 0.
- Requester protocol: after seeing gnt[i]=1, the requester either drops req[i] or presents new operands. Either is legal in the same cycle gnt is high.
- Invariants: gnt is zero or one-hot. No starvation: any continuously asserted req is granted within NREQ+1 cycles.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then req=0 for 5 cycles → all outputs 0, y_valid never asserts, gnt stays 0.
- Single requester, Width=16: req[2]=1 with A=100, B=−30, held until gnt → gnt=0100 once. The next cycle has y=70, y_id=2, y_valid=1, y_sat=0. Continuous req gives a grant every other cycle.
- Saturation:
  - Req0 with A=0x7000, B=0x2000 → y=0x7FFF, y_sat=1.
  - Req1 with A=0x8001, B=0xFFF0 → y=0x8000, y_sat=1.
  - sat_cnt=2 afterwards. sat_clr pulsed together with a third clipped result → sat_cnt=0.
- Round-robin: all 4 req held high → grant order 0,1,2,3,0,… with y_valid every cycle, y_id matching, and no index granted in consecutive cycles.
- Counter ceiling: CNTW=8, force 260 clipped results → sat_cnt stops at 255.
- Reset mid-operation: assert rst_n=0 at the edge right after a grant → no y_valid for that op. The next arbitration starts at requester 0 regardless of the prior ptr.
